// File: rtl/pc_seq_ctrl_if.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_ctrl_if
// Description : Decoder/ALU-facing bundle of the instruction-cycle sequencer.
//               The master side drives the instruction strobes and page bits.
//               The slave side (the sequencer) returns phase, strobes, PC and
//               stack status.
// Revision    : 1.0 - initial release
// ============================================================================
interface pc_seq_ctrl_if #(
    parameter int PC_W = 9
);
    // decoder / ALU -> sequencer
    logic            goto_i;
    logic            call_i;
    logic            retlw_i;
    logic            sleep_i;
    logic            fsz_i;
    logic            skip_cond_i;
    logic            pcl_wr_i;
    logic [7:0]      pcl_data_i;
    logic [8:0]      k_i;
    logic [1:0]      pa_i;
    logic            wake_i;

    // sequencer -> program memory / decoder / ALU
    logic [1:0]      q_o;
    logic            exec_stb_o;
    logic            ir_ld_o;
    logic            squash_o;
    logic [PC_W-1:0] pc_o;
    logic [1:0]      stk_depth_o;
    logic            stk_ovf_o;
    logic            stk_unf_o;
    logic            sleeping_o;

    modport master (
        output goto_i, call_i, retlw_i, sleep_i, fsz_i, skip_cond_i,
               pcl_wr_i, pcl_data_i, k_i, pa_i, wake_i,
        input  q_o, exec_stb_o, ir_ld_o, squash_o, pc_o,
               stk_depth_o, stk_ovf_o, stk_unf_o, sleeping_o
    );

    modport slave (
        input  goto_i, call_i, retlw_i, sleep_i, fsz_i, skip_cond_i,
               pcl_wr_i, pcl_data_i, k_i, pa_i, wake_i,
        output q_o, exec_stb_o, ir_ld_o, squash_o, pc_o,
               stk_depth_o, stk_ovf_o, stk_unf_o, sleeping_o
    );
endinterface
`default_nettype wire

// File: rtl/pc_seq_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : pc_seq_ctrl
// Description : Instruction-cycle sequencer and program-flow controller.
//               Generates Q1-Q4 phases, owns the PC and the two-level
//               hardware stack, squashes the prefetched slot after taken
//               flow changes, and implements SLEEP / wake.
// Revision    : 1.0 - initial release
// ============================================================================
module pc_seq_ctrl #(
    parameter int              PC_W      = 9,
    parameter logic [PC_W-1:0] RESET_VEC = '1
) (
    input  wire logic        clk,
    input  wire logic        rst_n,
    pc_seq_ctrl_if.slave     bus
);

    localparam logic [PC_W-1:0] c_PC_ONE = {{(PC_W-1){1'b0}}, 1'b1};
    localparam logic [1:0]      c_Q4     = 2'd3;

    typedef enum logic [0:0] {
        ST_RUN   = 1'b0,
        ST_SLEEP = 1'b1
    } state_t;

    state_t          r_state;
    logic [1:0]      r_q;
    logic [PC_W-1:0] r_pc;
    logic            r_squash;
    logic [PC_W-1:0] r_stk1;
    logic [PC_W-1:0] r_stk2;
    logic [1:0]      r_depth;
    logic            r_ovf;
    logic            r_unf;

    logic [PC_W-1:0] w_pc_inc;
    logic [PC_W-1:0] w_goto_tgt;
    logic [PC_W-1:0] w_call_tgt;
    logic [PC_W-1:0] w_pcl_tgt;
    logic            w_q4;
    logic            w_unused_pa;

    assign w_pc_inc = r_pc + c_PC_ONE;
    assign w_q4     = (r_state == ST_RUN) && (r_q == c_Q4);

    // Page bits are only consumed on wide PCs; this keeps the unused ones quiet.
    assign w_unused_pa = ^bus.pa_i;

    // Branch targets: page bits from STATUS fill everything above bit 8.
    generate
        if (PC_W > 9) begin : g_paged
            assign w_goto_tgt = {bus.pa_i[PC_W-10:0], bus.k_i};
            assign w_call_tgt = {bus.pa_i[PC_W-10:0], 1'b0, bus.k_i[7:0]};
            assign w_pcl_tgt  = {bus.pa_i[PC_W-10:0], 1'b0, bus.pcl_data_i};
        end else begin : g_unpaged
            assign w_goto_tgt = bus.k_i;
            assign w_call_tgt = {1'b0, bus.k_i[7:0]};
            assign w_pcl_tgt  = {1'b0, bus.pcl_data_i};
        end
    endgenerate

    // Phase counter, run/sleep state, PC, squash flag and stack; all flow
    // changes land on the edge that closes Q4.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state  <= ST_RUN;
            r_q      <= 2'd0;
            r_pc     <= RESET_VEC;
            r_squash <= 1'b1;
            r_stk1   <= '0;
            r_stk2   <= '0;
            r_depth  <= 2'd0;
            r_ovf    <= 1'b0;
            r_unf    <= 1'b0;
        end else begin
            case (r_state)
                ST_RUN: begin
                    r_q <= r_q + 2'd1;
                    if (r_q == c_Q4) begin
                        if (r_squash) begin
                            // forced NOP: strobes of this slot are ignored
                            r_pc     <= w_pc_inc;
                            r_squash <= 1'b0;
                        end else if (bus.goto_i) begin
                            r_pc     <= w_goto_tgt;
                            r_squash <= 1'b1;
                        end else if (bus.call_i) begin
                            r_stk2   <= r_stk1;
                            r_stk1   <= r_pc;
                            if (r_depth == 2'd2) begin
                                r_ovf <= 1'b1;
                            end else begin
                                r_depth <= r_depth + 2'd1;
                            end
                            r_pc     <= w_call_tgt;
                            r_squash <= 1'b1;
                        end else if (bus.retlw_i) begin
                            // an underflowing pop still returns to stk1
                            r_pc     <= r_stk1;
                            r_stk1   <= r_stk2;
                            if (r_depth == 2'd0) begin
                                r_unf <= 1'b1;
                            end else begin
                                r_depth <= r_depth - 2'd1;
                            end
                            r_squash <= 1'b1;
                        end else if (bus.pcl_wr_i) begin
                            r_pc     <= w_pcl_tgt;
                            r_squash <= 1'b1;
                        end else if (bus.fsz_i && bus.skip_cond_i) begin
                            r_pc     <= w_pc_inc;
                            r_squash <= 1'b1;
                        end else if (bus.sleep_i) begin
                            // PC already points at the instruction to run on wake
                            r_state <= ST_SLEEP;
                            r_q     <= 2'd0;
                        end else begin
                            r_pc <= w_pc_inc;
                        end
                    end
                end
                ST_SLEEP: begin
                    r_q <= 2'd0;
                    if (bus.wake_i) begin
                        r_state <= ST_RUN;
                    end
                end
                default: begin
                    r_state <= ST_RUN;
                    r_q     <= 2'd0;
                end
            endcase
        end
    end

    assign bus.q_o         = r_q;
    assign bus.ir_ld_o     = w_q4;
    assign bus.exec_stb_o  = w_q4 & ~r_squash;
    assign bus.squash_o    = r_squash;
    assign bus.pc_o        = r_pc;
    assign bus.stk_depth_o = r_depth;
    assign bus.stk_ovf_o   = r_ovf;
    assign bus.stk_unf_o   = r_unf;
    assign bus.sleeping_o  = (r_state == ST_SLEEP);

endmodule
`default_nettype wire
